// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and packet sequencer that shares one byte-level UART
//   transmitter among NUM_REQ requesters. A granted requester's PKT_LEN-byte
//   packet is latched, then sent byte 0 first through a start/busy/done
//   handshake with the TX core. Completion and per-byte timeout are reported
//   as single-cycle pulses.
//
//   Optional build macro UART_TX_ARB_CHKSUM_EN: when defined, an XOR checksum
//   of the packet bytes is sent as one extra trailing byte before pkt_done.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester packet-ready level
//   req_data     : packed packets, requester i at [i*8*PKT_LEN +: 8*PKT_LEN]
//   req_ack      : one-hot one-cycle pulse when a packet is latched
//   byte_start   : one-cycle start pulse to the TX core
//   byte_data    : byte to send, held until the next byte_start
//   byte_busy    : TX core busy
//   byte_done    : TX core byte-complete pulse
//   grant_id     : index of the current or last granted requester
//   busy         : high whenever the sequencer is not idle
//   pkt_done     : one-cycle pulse after the final byte completes
//   err_timeout  : one-cycle pulse when a byte times out and the packet drops
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PKT_LEN      = 8,
  parameter int unsigned BYTE_TIMEOUT = 200_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*8*PKT_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         byte_start,
  output logic [7:0]                   byte_data,
  input  logic                         byte_busy,
  input  logic                         byte_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         pkt_done,
  output logic                         err_timeout
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned PB = 8 * PKT_LEN;
`ifdef UART_TX_ARB_CHKSUM_EN
  localparam int unsigned NBYTES = PKT_LEN + 1;
`else
  localparam int unsigned NBYTES = PKT_LEN;
`endif
  localparam int unsigned IW = $clog2(NBYTES + 1);
  localparam int unsigned CW = $clog2(BYTE_TIMEOUT + 2);

  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(BYTE_TIMEOUT - 1);
  localparam logic [PW:0]   NR_W     = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] PICK_MAX = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PB-1:0]       buf_q, buf_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic                byte_start_q, byte_start_d;
  logic [7:0]          byte_data_q, byte_data_d;
  logic [PW-1:0]       grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                pkt_done_q, pkt_done_d;
  logic                err_q, err_d;
`ifdef UART_TX_ARB_CHKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  // Arbitration / datapath helpers
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  logic [PW-1:0]        off;
  logic [PW:0]          sum;
  logic [PW-1:0]        pick;
  logic [PB-1:0]        slice;
  logic [7:0]           slice_xor;
  logic [7:0]           byte_sel;
  logic [7:0]           cur_byte;
  logic                 timeout_hit;

  // Rotate requests so the RR pointer sits at bit 0; the first set bit is then
  // the winning offset, mapped back to an absolute index with a single wrap.
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_q;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int unsigned o = 0; o < NUM_REQ; o++) begin
      if (!found && rot[o]) begin
        found = 1'b1;
        off   = PW'(o);
      end
    end
    sum  = {1'b0, rr_q} + {1'b0, off};
    pick = (sum >= NR_W) ? PW'(sum - NR_W) : PW'(sum);
  end

  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == PW'(i)) slice = req_data[i*PB +: PB];
    end
    slice_xor = '0;
    for (int unsigned k = 0; k < PKT_LEN; k++) begin
      slice_xor = slice_xor ^ slice[8*k +: 8];
    end
    byte_sel = '0;
    for (int unsigned k = 0; k < PKT_LEN; k++) begin
      if (idx_q == IW'(k)) byte_sel = buf_q[8*k +: 8];
    end
`ifdef UART_TX_ARB_CHKSUM_EN
    cur_byte = (idx_q == IW'(PKT_LEN)) ? chk_q : byte_sel;
`else
    cur_byte = byte_sel;
`endif
    // cnt_q holds (WAIT cycles elapsed - 1), so this fires on the
    // BYTE_TIMEOUT-th WAIT cycle.
    timeout_hit = (BYTE_TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  // State register (plus all datapath/output flops)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      req_ack_q    <= '0;
      byte_start_q <= 1'b0;
      byte_data_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      pkt_done_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef UART_TX_ARB_CHKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      req_ack_q    <= req_ack_d;
      byte_start_q <= byte_start_d;
      byte_data_q  <= byte_data_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      pkt_done_q   <= pkt_done_d;
      err_q        <= err_d;
`ifdef UART_TX_ARB_CHKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (found) state_d = S_SEND;
      S_SEND: if (!byte_busy) state_d = S_WAIT;
      S_WAIT: begin
        if (byte_done)        state_d = (idx_q == LAST_IDX) ? S_DONE : S_SEND;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic; every output is registered, so pulses appear in
  // the cycle after the decision (e.g. pkt_done is high while in DONE).
  always_comb begin
    rr_d         = rr_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    grant_d      = grant_q;
    byte_data_d  = byte_data_q;
    req_ack_d    = '0;
    byte_start_d = 1'b0;
    pkt_done_d   = 1'b0;
    err_d        = 1'b0;
`ifdef UART_TX_ARB_CHKSUM_EN
    chk_d        = chk_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          buf_d     = slice;
          req_ack_d = NUM_REQ'(1) << pick;
          grant_d   = pick;
          rr_d      = (pick == PICK_MAX) ? '0 : PW'(pick + 1'b1);
          idx_d     = '0;
`ifdef UART_TX_ARB_CHKSUM_EN
          chk_d     = slice_xor;
`endif
        end
      end
      S_SEND: begin
        if (!byte_busy) begin
          byte_start_d = 1'b1;
          byte_data_d  = cur_byte;
          cnt_d        = '0;
        end
      end
      S_WAIT: begin
        if (BYTE_TIMEOUT != 0) cnt_d = cnt_q + 1'b1;
        if (byte_done) begin
          if (idx_q == LAST_IDX) pkt_done_d = 1'b1;
          else                   idx_d      = idx_q + 1'b1;
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign req_ack     = req_ack_q;
  assign byte_start  = byte_start_q;
  assign byte_data   = byte_data_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign pkt_done    = pkt_done_q;
  assign err_timeout = err_q;

`ifndef UART_TX_ARB_CHKSUM_EN
  logic unused_xor;
  assign unused_xor = ^slice_xor;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, PKT_LEN=4, BYTE_TIMEOUT=20).
// Contains a behavioural TX core and a byte scoreboard. Works with or without
// UART_TX_ARB_CHKSUM_EN defined.
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned PL = 4;
  localparam int unsigned TO = 20;
`ifdef UART_TX_ARB_CHKSUM_EN
  localparam int unsigned NB = PL + 1;
`else
  localparam int unsigned NB = PL;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*8*PL-1:0] req_data;
  logic [NR-1:0]  req_ack;
  logic           byte_start;
  logic [7:0]     byte_data;
  logic           byte_busy;
  logic           byte_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           pkt_done;
  logic           err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .PKT_LEN(PL), .BYTE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .byte_start(byte_start), .byte_data(byte_data),
    .byte_busy(byte_busy), .byte_done(byte_done), .grant_id(grant_id),
    .busy(busy), .pkt_done(pkt_done), .err_timeout(err_timeout)
  );

  logic [31:0] d [NR];
  assign req_data = {d[3], d[2], d[1], d[0]};

  // Behavioural TX core state
  logic model_busy, force_busy, done_r;
  int   tx_cnt;
  int   tx_lat;
  bit   tx_respond;
  assign byte_busy = model_busy | force_busy;
  assign byte_done = done_r;

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int nstarts = 0, npkt = 0, nerr = 0, nacks = 0;

  typedef struct {
    logic [3:0] mask;
    int         exp_gnt;
    logic [3:0] exp_ack;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int r);
    logic [31:0] w;
    logic [7:0]  x;
    w = d[r];
    x = '0;
    for (int k = 0; k < int'(PL); k++) begin
      exp_q.push_back(w[8*k +: 8]);
      x = x ^ w[8*k +: 8];
    end
`ifdef UART_TX_ARB_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // One clock: sample at negedge, run TX model and scoreboard monitor.
  task automatic step();
    @(negedge clk);
    done_r = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        done_r     = 1'b1;
        model_busy = 1'b0;
      end
    end
    if (byte_start === 1'b1) begin
      nstarts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL byte_start_unexpected: got byte %02h, required no byte_start", byte_data);
      end else begin
        check("byte_data", {24'b0, byte_data}, {24'b0, exp_q.pop_front()});
      end
      if (tx_respond) begin
        model_busy = 1'b1;
        tx_cnt     = tx_lat;
      end
    end
    if (req_ack !== '0) begin
      nacks++;
      check("ack_onehot", {31'b0, $onehot(req_ack)}, 32'd1);
    end
    if (pkt_done === 1'b1) npkt++;
    if (err_timeout === 1'b1) nerr++;
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (req_ack !== '0) begin
        n = i;
        break;
      end
    end
    if (n < 0) check("ack_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_pkt();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (pkt_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("pkt_done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {14'b0, req_ack, byte_start, byte_data, grant_id, busy, pkt_done, err_timeout}, 32'd0);
  endtask

  initial begin
    int n, s0, p0, e0, a0, cnt;
    int order [6];
    bit ok;

    d[0] = 32'hA1B2C3D4;
    d[1] = 32'h0F1E2D3C;
    d[2] = 32'h44332211;
    d[3] = 32'hDEADBEEF;
    tbl[0] = '{4'b0100, 2, 4'b0100};
    tbl[1] = '{4'b1011, 3, 4'b1000};
    tbl[2] = '{4'b0011, 0, 4'b0001};
    tbl[3] = '{4'b0011, 1, 4'b0010};
    tbl[4] = '{4'b0001, 0, 4'b0001};
    tbl[5] = '{4'b1001, 3, 4'b1000};
    tbl[6] = '{4'b1111, 0, 4'b0001};
    tbl[7] = '{4'b1100, 2, 4'b0100};
    order = '{0, 1, 3, 0, 1, 3};

    rst = 1'b1; req_valid = '0;
    model_busy = 1'b0; force_busy = 1'b0; done_r = 1'b0;
    tx_cnt = 0; tx_lat = 3; tx_respond = 1'b1;

    repeat (3) step();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    step();
    check("idle_after_reset", {31'b0, busy}, 32'd0);

    // Table-driven arbitration: each row is one full packet.
    for (int v = 0; v < 8; v++) begin
      req_valid = tbl[v].mask;
      wait_ack(n);
      if (n > 0) begin
        check("ack_latency", n, 32'd1);
        check("req_ack", {28'b0, req_ack}, {28'b0, tbl[v].exp_ack});
        check("grant_id", {30'b0, grant_id}, tbl[v].exp_gnt);
        check("busy_in_pkt", {31'b0, busy}, 32'd1);
        push_pkt(tbl[v].exp_gnt);
      end
      req_valid = '0;
      s0 = nstarts;
      wait_pkt();
      check("bytes_per_pkt", nstarts - s0, NB);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      step();
      check("idle_after_done", {31'b0, busy}, 32'd0);
    end

    // Reset during WAIT of byte 2: silent abandon, pointer back to 0.
    req_valid = 4'b0100;
    wait_ack(n);
    check("rst_test_grant", {30'b0, grant_id}, 32'd2);
    push_pkt(2);
    req_valid = '0;
    s0 = nstarts;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (nstarts - s0 == 3) begin ok = 1'b1; break; end
    end
    if (!ok) check("third_byte_wait_expired", 32'd0, 32'd1);
    p0 = npkt; e0 = nerr;
    rst = 1'b1;
    step();
    check_all_zero("midpkt_reset_outputs");
    tx_cnt = 0; model_busy = 1'b0; done_r = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    repeat (3) step();
    check("reset_no_pkt_done", npkt - p0, 32'd0);
    check("reset_no_err", nerr - e0, 32'd0);

    // Continuous requests 0,1,3: fair rotation starting at 0.
    req_valid = 4'b1011;
    a0 = nacks;
    for (int g = 0; g < 6; g++) begin
      wait_ack(n);
      check("rr_grant", {30'b0, grant_id}, order[g]);
      check("rr_ack", {28'b0, req_ack}, 32'd1 << order[g]);
      push_pkt(order[g]);
      wait_pkt();
      check("acks_per_pkt", nacks - a0, g + 1);
    end
    req_valid = '0;
    repeat (3) step();
    check("rr_total_acks", nacks - a0, 32'd6);
    check("rr_idle", {31'b0, busy}, 32'd0);

    // byte_busy held for 50 cycles after grant.
    force_busy = 1'b1;
    req_valid = 4'b0010;
    wait_ack(n);
    check("busy_test_grant", {30'b0, grant_id}, 32'd1);
    push_pkt(1);
    req_valid = '0;
    s0 = nstarts;
    repeat (50) step();
    check("no_start_while_busy", nstarts - s0, 32'd0);
    force_busy = 1'b0;
    step();
    check("start_after_busy", {31'b0, byte_start}, 32'd1);
    wait_pkt();
    check("busy_test_bytes", nstarts - s0, NB);

    // Timeout: first byte never completes.
    tx_respond = 1'b0;
    req_valid = 4'b1001;
    wait_ack(n);
    check("to_test_grant", {30'b0, grant_id}, 32'd3);
    push_pkt(3);
    req_valid = 4'b0001;
    p0 = npkt; e0 = nerr;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (byte_start === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check("to_first_start_expired", 32'd0, 32'd1);
    cnt = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (err_timeout === 1'b1) begin cnt = i; break; end
    end
    check("timeout_cycles", cnt, 32'd20);
    exp_q.delete();
    tx_respond = 1'b1;
    tx_lat = 19;  // byte_done lands on the same cycle the timeout would fire
    wait_ack(n);
    check("err_single_pulse", {31'b0, err_timeout}, 32'd0);
    check("err_count", nerr - e0, 32'd1);
    check("no_pkt_done_on_timeout", npkt - p0, 32'd0);
    check("after_to_latency", n, 32'd1);
    check("after_to_grant", {30'b0, grant_id}, 32'd0);
    push_pkt(0);
    req_valid = '0;
    e0 = nerr;
    s0 = nstarts;
    wait_pkt();
    check("done_beats_timeout", nerr - e0, 32'd0);
    check("done_beats_timeout_bytes", nstarts - s0, NB);
    repeat (3) step();
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and packet sequencer that shares one byte-level UART transmitter among NUM_REQ requesters. Each requester offers a fixed-length packet of PKT_LEN bytes. The block grants one requester and latches its packet. It then feeds the bytes one at a time to the transmitter core through a start/busy/done handshake, and reports completion or timeout. It is the transmit-side counterpart of the multi-byte RX frame controller in the UART subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PKT_LEN, 8, bytes per packet (1..64)
BYTE_TIMEOUT, 200_000, max clk cycles to wait for byte_done after a byte_start; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester packet-ready level
req_data  in  NUM_REQ*8*PKT_LEN  packed packets; requester i occupies slice [i*8*PKT_LEN +: 8*PKT_LEN]; byte k of a packet is bits [8k+7:8k]
req_ack  out  NUM_REQ  one-cycle one-hot pulse when requester i's packet is latched
byte_start  out  1  one-cycle pulse to the UART TX core
byte_data  out  8  byte to send; valid when byte_start=1 and held until the next byte_start
byte_busy  in  1  TX core busy
byte_done  in  1  TX core one-cycle pulse when a byte has fully shifted out
grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester
busy  out  1  high while any state other than IDLE
pkt_done  out  1  one-cycle pulse when the last byte's byte_done is received
err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0; FSM to IDLE; RR pointer 0 (requester 0 has highest priority first); byte index and timeout counter cleared. Reset mid-packet abandons the packet silently: no pkt_done, no error.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE: if any req_valid is set, choose the first set bit at or after the RR pointer, searching upward with wrap. In the same cycle:
  - latch that requester's slice into the internal buffer
  - pulse req_ack[i]
  - set grant_id=i
  - set the RR pointer to (i+1) mod NUM_REQ
  - clear the byte index
  - go to SEND
  Latency from req_valid to req_ack is 1 cycle (registered).
- Requester rule: req_data must be stable while req_valid is high. Dropping req_valid after req_ack means the requester will not be re-granted for the same packet. If req_valid is still high after req_ack, it is treated as a new packet and is eligible at the next arbitration.
- SEND: wait until byte_busy=0. Then pulse byte_start with byte_data=buf[idx], clear the timeout counter and go to WAIT. byte_done received in SEND is ignored.
- WAIT: count cycles.
  - On byte_done with idx<PKT_LEN-1: idx++ and go to SEND.
  - On byte_done with idx=PKT_LEN-1: go to DONE.
  - If BYTE_TIMEOUT≠0 and the counter reaches BYTE_TIMEOUT before byte_done: pulse err_timeout, drop the packet and go to IDLE (no pkt_done).
  - byte_done and timeout in the same cycle: byte_done wins.
- DONE: pulse pkt_done for 1 cycle and go to IDLE. The next arbitration can grant in the following cycle.
- Minimum gap is 2 cycles between byte_done and the next byte_start (WAIT→SEND→start).
- Byte order: byte 0 (LSB of the slice) is sent first.
- Requesters that are not granted see no req_ack. Their requests stay pending and are never lost.
- busy=1 in SEND, WAIT and DONE.

Optional Feature:
UART_TX_ARB_CHKSUM_EN
- Defined: after byte PKT_LEN-1 completes, one extra byte is sent through the same SEND/WAIT handshake before DONE. Its value is the XOR of all PKT_LEN latched bytes, computed during latch. The timeout applies to this byte too. pkt_done fires after the checksum byte's byte_done.
- Undefined: exactly PKT_LEN bytes are sent and there is no checksum logic.

Test Plan:
1. NUM_REQ=4, PKT_LEN=4. Only req 2 valid with data 0x44332211 -> req_ack=0b0100, grant_id=2. byte_data sequence is 0x11,0x22,0x33,0x44, with one byte_start per byte_done. pkt_done pulses once.
2. Reqs 0,1,3 held valid continuously -> grant order 0,1,3,0,1,3. Each req_ack is one-hot and there are no back-to-back grants without DONE.
3. byte_busy held 1 for 50 cycles on entering SEND -> no byte_start until byte_busy=0, then byte_start on the next cycle.
4. BYTE_TIMEOUT=20 and byte_done never returns after the first byte -> err_timeout pulses on the 20th WAIT cycle. No pkt_done. FSM goes to IDLE and the next requester is granted.
5. rst asserted during WAIT of byte 2 -> next cycle all outputs 0 and state IDLE. After release, req 0 wins first.
6. With UART_TX_ARB_CHKSUM_EN, data 0x44332211 -> 5th byte 0x44 (0x11^0x22^0x33^0x44). pkt_done follows the 5th byte_done.
